// File: rtl/msx_bank_mapper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msx_bank_mapper_pkg
// Description : Shared MSX cartridge types: mapper kinds, ROM lookup entry,
//               bank register type, reset bank values and the mapper FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package msx_bank_mapper_pkg;

    // Cartridge mapper kinds. Encodings 6 and 7 are unused and decode as NONE.
    typedef enum logic [2:0] {
        MAPPER_NONE       = 3'd0,
        MAPPER_LINEAR     = 3'd1,
        MAPPER_ASCII8     = 3'd2,
        MAPPER_ASCII16    = 3'd3,
        MAPPER_KONAMI     = 3'd4,
        MAPPER_KONAMI_SCC = 3'd5
    } mapper_typ_t;

    localparam int ROM_ADDR_W = 27;
    localparam int ROM_SIZE_W = 16;

    // Per-cartridge ROM placement: base address, size in 16 KB units
    // (power of two) and a read-only flag.
    typedef struct packed {
        logic [ROM_ADDR_W-1:0] addr;
        logic [ROM_SIZE_W-1:0] size;
        logic                  ro;
    } lookup_RAM_t;

    localparam int MAPPER_BANK_W = 8;
    typedef logic [MAPPER_BANK_W-1:0] mapper_bank_t;

    // Power-up bank contents. Konami-style carts start with a linear
    // 0,1,2,3 layout; ASCII carts start with every window on bank 0.
    localparam mapper_bank_t BANK_RST_KONAMI_0 = 8'd0;
    localparam mapper_bank_t BANK_RST_KONAMI_1 = 8'd1;
    localparam mapper_bank_t BANK_RST_KONAMI_2 = 8'd2;
    localparam mapper_bank_t BANK_RST_KONAMI_3 = 8'd3;
    localparam mapper_bank_t BANK_RST_ASCII    = 8'd0;

    // Reset value of bank register n for mapper kind m.
    function automatic mapper_bank_t reset_bank(input mapper_typ_t m, input logic [1:0] n);
        mapper_bank_t v;
        v = BANK_RST_ASCII;
        if (m == MAPPER_KONAMI || m == MAPPER_KONAMI_SCC) begin
            case (n)
                2'd0:    v = BANK_RST_KONAMI_0;
                2'd1:    v = BANK_RST_KONAMI_1;
                2'd2:    v = BANK_RST_KONAMI_2;
                default: v = BANK_RST_KONAMI_3;
            endcase
        end
        return v;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XLATE = 2'd1,
        ST_WAIT  = 2'd2
    } xlate_state_t;

endpackage
`default_nettype wire

// File: rtl/msx_bank_decode.sv
`default_nettype none
// ============================================================================
// Module      : msx_bank_decode
// Description : Combinational decode of a Z80 access for one cartridge:
//               bank register write enables/data, ROM window hit, and which
//               8 KB bank register serves the address.
// Revision    : 1.0 - initial release
// ============================================================================
module msx_bank_decode
    import msx_bank_mapper_pkg::*;
#(
    parameter int BANK_W = 8
) (
    input  mapper_typ_t               mapper_i,
    input  logic [4:0]                addr_hi_i,     // Z80 address bits 15:11
    input  logic [7:0]                data_i,
    output logic [3:0]                bank_we_o,
    output logic [3:0][BANK_W-1:0]    bank_wdata_o,
    output logic                      in_window_o,
    output logic                      banked_o,
    output logic [1:0]                bank_idx_o
);

    logic [2:0] w_page;     // 8 KB page number (address bits 15:13)
    logic       w_mid_32k;  // address inside 4000h-BFFFh

    assign w_page    = addr_hi_i[4:2];
    assign w_mid_32k = (w_page >= 3'd2) && (w_page <= 3'd5);
    // 4000h->0, 6000h->1, 8000h->2, A000h->3
    assign bank_idx_o = addr_hi_i[3:2] ^ 2'b10;

    // Per-mapper register decode and window classification.
    always_comb begin
        bank_we_o    = 4'b0000;
        bank_wdata_o = {4{BANK_W'(data_i)}};
        in_window_o  = w_mid_32k;
        banked_o     = 1'b0;
        case (mapper_i)
            MAPPER_LINEAR: begin
                in_window_o = 1'b1;
            end
            MAPPER_ASCII8: begin
                banked_o = 1'b1;
                if (w_page == 3'd3) begin
                    bank_we_o[addr_hi_i[1:0]] = 1'b1;
                end
            end
            MAPPER_ASCII16: begin
                banked_o = 1'b1;
                // A 16 KB bank number d selects the 8 KB pair 2d, 2d+1.
                bank_wdata_o[0] = BANK_W'({data_i, 1'b0});
                bank_wdata_o[1] = BANK_W'({data_i, 1'b1});
                bank_wdata_o[2] = BANK_W'({data_i, 1'b0});
                bank_wdata_o[3] = BANK_W'({data_i, 1'b1});
                if (addr_hi_i == 5'b01100) begin
                    bank_we_o[1:0] = 2'b11;
                end
                if (addr_hi_i == 5'b01110) begin
                    bank_we_o[3:2] = 2'b11;
                end
            end
            MAPPER_KONAMI: begin
                banked_o = 1'b1;
                // Bank 0 is hard-wired on plain Konami carts.
                case (w_page)
                    3'd3:    bank_we_o[1] = 1'b1;
                    3'd4:    bank_we_o[2] = 1'b1;
                    3'd5:    bank_we_o[3] = 1'b1;
                    default: bank_we_o    = 4'b0000;
                endcase
            end
            MAPPER_KONAMI_SCC: begin
                banked_o = 1'b1;
                case (addr_hi_i)
                    5'b01010: bank_we_o[0] = 1'b1;
                    5'b01110: bank_we_o[1] = 1'b1;
                    5'b10010: bank_we_o[2] = 1'b1;
                    5'b10110: bank_we_o[3] = 1'b1;
                    default:  bank_we_o    = 4'b0000;
                endcase
            end
            default: begin
                in_window_o = w_mid_32k;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/msx_bank_mapper.sv
`default_nettype none
// ============================================================================
// Module      : msx_bank_mapper
// Description : Multi-cartridge MSX bank mapper. Accepts one Z80 access at a
//               time, updates the cartridge bank registers and translates the
//               access to a flat memory address with a held rd/wr strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module msx_bank_mapper
    import msx_bank_mapper_pkg::*;
#(
    parameter  int CARTS  = 2,
    parameter  int BANK_W = 8,
    parameter  int ADDR_W = 27,
    localparam int CART_W = (CARTS > 1) ? $clog2(CARTS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              req_wr,
    input  logic [CART_W-1:0] req_cart,
    input  logic [15:0]       req_addr,
    input  logic [7:0]        req_data,
    input  mapper_typ_t       mapper [CARTS],
    input  lookup_RAM_t       rom    [CARTS],
    output logic              ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ack,
    output logic              unmapped
);

    xlate_state_t      state_q, state_d;
    logic              wr_q;
    logic [CART_W-1:0] cart_q;
    logic [15:0]       addr_q;
    logic [7:0]        data_q;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic              unmapped_q, unmapped_d;
    logic [3:0]        bank_we;

    logic [BANK_W-1:0] bank_q [CARTS][4];

    mapper_typ_t           w_map_sel;
    lookup_RAM_t           w_rom_sel;
    logic [3:0]            w_dec_we;
    logic [3:0][BANK_W-1:0] w_dec_wdata;
    logic                  w_dec_win;
    logic                  w_dec_banked;
    logic [1:0]            w_dec_idx;
    logic [BANK_W-1:0]     w_bank_cur;
    logic [BANK_W-1:0]     w_bank_mask;
    logic [ADDR_W-1:0]     w_rom_bytes;
    logic [ADDR_W-1:0]     w_lin_off;
    logic [ADDR_W-1:0]     w_bank_off;
    logic [ADDR_W-1:0]     w_xlate_addr;

    assign w_map_sel = mapper[cart_q];
    assign w_rom_sel = rom[cart_q];

    msx_bank_decode #(
        .BANK_W (BANK_W)
    ) u_decode (
        .mapper_i     (w_map_sel),
        .addr_hi_i    (addr_q[15:11]),
        .data_i       (data_q),
        .bank_we_o    (w_dec_we),
        .bank_wdata_o (w_dec_wdata),
        .in_window_o  (w_dec_win),
        .banked_o     (w_dec_banked),
        .bank_idx_o   (w_dec_idx)
    );

    // Address translation uses the bank value as it stood before this
    // transaction's own register write.
    assign w_bank_cur   = bank_q[cart_q][w_dec_idx];
    assign w_bank_mask  = BANK_W'({w_rom_sel.size, 1'b0}) - BANK_W'(1);
    assign w_bank_off   = (ADDR_W'(w_bank_cur & w_bank_mask) << 13) + ADDR_W'(addr_q[12:0]);
    assign w_rom_bytes  = ADDR_W'(w_rom_sel.size) << 14;
    assign w_lin_off    = (ADDR_W'(addr_q) - ADDR_W'(32'h4000)) & (w_rom_bytes - ADDR_W'(1));
    assign w_xlate_addr = ADDR_W'(w_rom_sel.addr) + (w_dec_banked ? w_bank_off : w_lin_off);

    // Next-state and output decode for the IDLE -> XLATE -> WAIT sequence.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        unmapped_d = 1'b0;
        bank_we    = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_XLATE;
                end
            end
            ST_XLATE: begin
                if (wr_q) begin
                    bank_we = w_dec_we;
                end
                // A write to a read-only ROM only touches the bank registers.
                if (w_dec_win && (!wr_q || !w_rom_sel.ro)) begin
                    state_d    = ST_WAIT;
                    mem_addr_d = w_xlate_addr;
                    mem_rd_d   = !wr_q;
                    mem_wr_d   = wr_q;
                end else begin
                    state_d    = ST_IDLE;
                    unmapped_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d  = ST_IDLE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // State, output and request-capture registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            unmapped_q <= 1'b0;
            wr_q       <= 1'b0;
            cart_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            unmapped_q <= unmapped_d;
            if (state_q == ST_IDLE && req) begin
                wr_q   <= req_wr;
                cart_q <= req_cart;
                addr_q <= req_addr;
                data_q <= req_data;
            end
        end
    end

    // Bank register files, one set of four per cartridge channel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < CARTS; c++) begin
                for (int n = 0; n < 4; n++) begin
                    bank_q[c][n] <= BANK_W'(reset_bank(mapper[c], 2'(n)));
                end
            end
        end else begin
            for (int c = 0; c < CARTS; c++) begin
                for (int n = 0; n < 4; n++) begin
                    if (bank_we[n] && (cart_q == CART_W'(c))) begin
                        bank_q[c][n] <= w_dec_wdata[n];
                    end
                end
            end
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_wr   = mem_wr_q;
    assign unmapped = unmapped_q;

endmodule
`default_nettype wire

// File: tb/tb_msx_bank_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_msx_bank_mapper
// Description : Directed self-checking bench for msx_bank_mapper with a
//               reference bank model and an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msx_bank_mapper;
    import msx_bank_mapper_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic        req_wr;
    logic [0:0]  req_cart;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    mapper_typ_t mapper [2];
    lookup_RAM_t rom    [2];
    logic        ready;
    logic [26:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_ack;
    logic        unmapped;

    msx_bank_mapper #(
        .CARTS  (2),
        .BANK_W (8),
        .ADDR_W (27)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_wr   (req_wr),
        .req_cart (req_cart),
        .req_addr (req_addr),
        .req_data (req_data),
        .mapper   (mapper),
        .rom      (rom),
        .ready    (ready),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_ack  (mem_ack),
        .unmapped (unmapped)
    );

    always #5 clk = ~clk;

    // kind: 0 = unmapped pulse, 1 = mem_rd, 2 = mem_wr
    typedef struct {
        int          kind;
        logic [31:0] addr;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   mb[2][4];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int n = 0; n < 4; n++) begin
                mb[c][n] = (mapper[c] == MAPPER_KONAMI || mapper[c] == MAPPER_KONAMI_SCC) ? n : 0;
            end
        end
    endtask

    task automatic model_access(input int c, input bit wr, input int a, input int d,
                                output int kind, output logic [31:0] ea);
        mapper_typ_t m;
        int base, sz, mask, n, off, span;
        bit win, banked;
        m      = mapper[c];
        base   = int'(rom[c].addr);
        sz     = int'(rom[c].size);
        span   = sz * 'h4000;
        banked = (m == MAPPER_ASCII8) || (m == MAPPER_ASCII16) ||
                 (m == MAPPER_KONAMI) || (m == MAPPER_KONAMI_SCC);
        win    = (m == MAPPER_LINEAR) ? 1'b1 : (a >= 'h4000 && a < 'hC000);
        ea     = '0;
        if (win) begin
            if (banked) begin
                n    = (a - 'h4000) / 'h2000;
                mask = (sz * 2 - 1) & 'hFF;
                ea   = base + (mb[c][n] & mask) * 'h2000 + (a % 'h2000);
            end else begin
                off = (a - 'h4000) % span;
                if (off < 0) off += span;
                ea = base + off;
            end
        end
        kind = !win ? 0 : (wr ? (rom[c].ro ? 0 : 2) : 1);
        if (wr) begin
            case (m)
                MAPPER_ASCII8: if (a >= 'h6000 && a < 'h8000) mb[c][(a >> 11) & 3] = d;
                MAPPER_ASCII16: begin
                    if (a >= 'h6000 && a < 'h6800) begin mb[c][0] = (2*d) & 'hFF; mb[c][1] = (2*d+1) & 'hFF; end
                    if (a >= 'h7000 && a < 'h7800) begin mb[c][2] = (2*d) & 'hFF; mb[c][3] = (2*d+1) & 'hFF; end
                end
                MAPPER_KONAMI: begin
                    if (a >= 'h6000 && a < 'h8000) mb[c][1] = d;
                    if (a >= 'h8000 && a < 'hA000) mb[c][2] = d;
                    if (a >= 'hA000 && a < 'hC000) mb[c][3] = d;
                end
                MAPPER_KONAMI_SCC: begin
                    if (a >= 'h5000 && a < 'h5800) mb[c][0] = d;
                    if (a >= 'h7000 && a < 'h7800) mb[c][1] = d;
                    if (a >= 'h9000 && a < 'h9800) mb[c][2] = d;
                    if (a >= 'hB000 && a < 'hB800) mb[c][3] = d;
                end
                default: ;
            endcase
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        req     = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One CPU access: predict, drive, wait (bounded) for the DUT response,
    // compare against the queued prediction, then complete the handshake.
    task automatic access(input int cart, input bit wr, input int addr, input int data,
                          input bit poke, input string tag);
        exp_t e, got;
        int   cyc;
        bit   seen;
        logic [2:0] exp_vec;
        model_access(cart, wr, addr, data, e.kind, e.addr);
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        req      = 1'b1;
        req_wr   = wr;
        req_cart = cart[0:0];
        req_addr = addr[15:0];
        req_data = data[7:0];
        @(negedge clk);
        req = 1'b0;
        cyc = 1;
        while (!(mem_rd || mem_wr || unmapped) && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        got     = sb.pop_front();
        exp_vec = (got.kind == 0) ? 3'b100 : (got.kind == 1) ? 3'b001 : 3'b010;
        chk({got.tag, "/kind"}, {29'b0, unmapped, mem_wr, mem_rd}, {29'b0, exp_vec});
        chk({got.tag, "/lat"}, cyc, 2);
        if (got.kind == 0) begin
            @(negedge clk);
            chk({got.tag, "/pulse_end"}, {30'b0, unmapped, ready}, 32'b01);
        end else begin
            chk({got.tag, "/addr"}, {5'b0, mem_addr}, got.addr);
            if (poke) begin
                req      = 1'b1;
                req_wr   = 1'b0;
                req_addr = 16'h4000;
                @(negedge clk);
                req = 1'b0;
                chk({got.tag, "/hold"}, {29'b0, mem_rd, mem_wr, ready}, {29'b0, exp_vec[0], exp_vec[1], 1'b0});
            end
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            chk({got.tag, "/done"}, {29'b0, mem_rd, mem_wr, ready}, 32'b001);
            if (poke) begin
                seen = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    if (mem_rd || mem_wr || unmapped) seen = 1'b1;
                end
                chk({got.tag, "/ignored_req"}, {31'b0, seen}, 32'b0);
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 1'b0;
        req_wr   = 1'b0;
        req_cart = 1'b0;
        req_addr = '0;
        req_data = '0;
        mem_ack  = 1'b0;

        // Reset state
        mapper[0] = MAPPER_KONAMI;      rom[0] = '{addr: 27'h100000, size: 16'd8, ro: 1'b1};
        mapper[1] = MAPPER_NONE;        rom[1] = '{addr: 27'h300000, size: 16'd2, ro: 1'b1};
        apply_reset();
        chk("rst/ready",    {31'b0, ready},    32'd1);
        chk("rst/strobes",  {29'b0, mem_rd, mem_wr, unmapped}, 32'd0);
        chk("rst/mem_addr", {5'b0, mem_addr},  32'd0);

        // Konami: reset banks 0,1,2,3; bank 0 fixed; writes to ROM only retarget banks
        access(0, 0, 'hA123, 0, 0, "konami_rd_a123");
        access(0, 1, 'h8000, 'h05, 0, "konami_wr_b2");
        access(0, 0, 'h8010, 0, 0, "konami_rd_b2");
        access(0, 1, 'h4000, 'h07, 0, "konami_wr_b0");
        access(0, 0, 'h4000, 0, 0, "konami_rd_b0");

        // ASCII16, 64 KB ROM: bank numbers wrap modulo the ROM size
        mapper[0] = MAPPER_ASCII16;     rom[0] = '{addr: 27'h020000, size: 16'd4, ro: 1'b1};
        apply_reset();
        access(0, 1, 'h6000, 'h20, 0, "a16_wr_6000");
        access(0, 0, 'h4010, 0, 0, "a16_rd_4010");
        access(0, 1, 'h7000, 'h03, 0, "a16_wr_7000");
        access(0, 0, 'hA005, 0, 0, "a16_rd_a005");

        // ASCII8 on both channels: registers are per channel
        mapper[0] = MAPPER_ASCII8;      rom[0] = '{addr: 27'h040000, size: 16'd8, ro: 1'b1};
        mapper[1] = MAPPER_ASCII8;      rom[1] = '{addr: 27'h080000, size: 16'd8, ro: 1'b1};
        apply_reset();
        access(0, 1, 'h7800, 'h05, 0, "a8_wr_b3");
        access(0, 0, 'hA000, 0, 0, "a8_rd_ch0");
        access(1, 0, 'hA000, 0, 0, "a8_rd_ch1");

        // NONE: window edges, writable RAM, request during WAIT ignored
        mapper[0] = MAPPER_NONE;        rom[0] = '{addr: 27'h010000, size: 16'd2, ro: 1'b0};
        apply_reset();
        access(0, 0, 'hC000, 0, 0, "none_rd_c000");
        access(0, 0, 'h4123, 0, 1, "none_rd_wait_req");
        access(0, 0, 'hBFFF, 0, 0, "none_rd_bfff");
        access(0, 1, 'h5000, 'hAA, 0, "none_wr_5000");
        access(0, 0, 'h3FFF, 0, 0, "none_rd_3fff");

        // Undefined mapper code behaves as NONE
        mapper[0] = mapper_typ_t'(3'd6); rom[0] = '{addr: 27'h010000, size: 16'd2, ro: 1'b1};
        apply_reset();
        access(0, 0, 'h8000, 0, 0, "undef_rd_8000");
        access(0, 0, 'hC000, 0, 0, "undef_rd_c000");

        // LINEAR: full 64 KB window, wraps modulo ROM size
        mapper[0] = MAPPER_LINEAR;      rom[0] = '{addr: 27'h050000, size: 16'd2, ro: 1'b1};
        apply_reset();
        access(0, 0, 'h0000, 0, 0, "lin_rd_0000");
        access(0, 0, 'hF000, 0, 0, "lin_rd_f000");

        // Konami SCC: register write, then reset during WAIT
        mapper[0] = MAPPER_KONAMI_SCC;  rom[0] = '{addr: 27'h200000, size: 16'd16, ro: 1'b1};
        apply_reset();
        access(0, 1, 'h9000, 'h09, 0, "scc_wr_b2");
        access(0, 0, 'h8000, 0, 0, "scc_rd_b2");
        access(0, 1, 'h9800, 'h0B, 0, "scc_wr_9800");
        access(0, 0, 'h8000, 0, 0, "scc_rd_b2_again");

        @(negedge clk);
        req      = 1'b1;
        req_wr   = 1'b0;
        req_cart = 1'b0;
        req_addr = 16'h8000;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("rstwait/strobe", {31'b0, mem_rd}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rstwait/drop", {29'b0, mem_rd, mem_wr, ready}, 32'b001);
        chk("rstwait/addr", {5'b0, mem_addr}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rstwait/late_ack", {28'b0, mem_rd, mem_wr, unmapped, ready}, 32'b0001);
        model_reset();
        access(0, 0, 'h8000, 0, 0, "scc_rd_after_rst");
        access(0, 0, 'h5000, 0, 0, "scc_rd_b0_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
